// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, multiplier FSM states, default width.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_MUL = 4'b1100;

  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier beside the execute-stage ALU.
// Returns the low WIDTH bits of src_a*src_b and stalls the datapath until ready.
//
// state | meaning
// IDLE  | waiting for a MUL request; stall follows the request combinationally
// RUN   | one shift-add step per cycle; stall held high
// DONE  | done pulse, result valid; stall low so the PC advances this edge
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int          WIDTH      = MUL_WIDTH,
  parameter logic [3:0]  MUL_CODE   = ALU_MUL,
  parameter int          EARLY_TERM = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             kill,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  mul_state_t state, state_next;

  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] acc_next, mplier_shift;
  logic             req, accept, zero_skip, last, finish;

  assign req          = start && (alu_control == MUL_CODE);
  assign acc_next     = mplier[0] ? (acc + mcand) : acc;
  assign mplier_shift = mplier >> 1;
  // Early exit looks at the multiplier after this cycle's shift, so a
  // multiplier whose top set bit is at index i takes exactly i+1 steps.
  assign last         = (cnt == CW'(WIDTH - 1)) ||
                        ((EARLY_TERM != 0) && (mplier_shift == '0));
  assign zero_skip    = (EARLY_TERM != 0) && (src_b == '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and handshake outputs; kill outranks the RUN exit.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept     = 1'b1;
          state_next = zero_skip ? DONE : RUN;
        end
      end
      RUN: begin
        if (kill) begin
          state_next = IDLE;
        end else if (last) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign stall = accept || (state == RUN);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  // Shift-add datapath; result only moves on a completing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= src_a;
      mplier <= src_b;
      cnt    <= '0;
      if (zero_skip) result <= '0;
    end else if ((state == RUN) && !kill) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier_shift;
      cnt    <= cnt + CW'(1);
      if (finish) result <= acc_next;
    end
  end

endmodule
